// File: rtl/packet_ring_buffer.sv
// Multi-slot packet FIFO: one packet per slot, byte-masked word writes, 1-cycle reads,
// commit/abort/ack slot management with occupancy and saturating drop-count status.
module packet_ring_buffer #(
   parameter  int unsigned slot_p           = 4,
   parameter  int unsigned data_width_p     = 64,
   parameter  int unsigned els_p            = 2048,
   parameter  int unsigned drop_cnt_width_p = 16,
   localparam int unsigned bytes_lp         = data_width_p / 8,
   localparam int unsigned words_lp         = els_p / bytes_lp,
   localparam int unsigned waddr_lp         = (words_lp > 1) ? $clog2(words_lp) : 1,
   localparam int unsigned size_lp          = $clog2(els_p + 1),
   localparam int unsigned cnt_lp           = $clog2(slot_p + 1)
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   output logic                        wr_req_o,
   input  logic                        wr_v_i,
   input  logic [waddr_lp-1:0]         wr_addr_i,
   input  logic [data_width_p-1:0]     wr_data_i,
   input  logic [bytes_lp-1:0]         wr_mask_i,
   input  logic                        wr_commit_i,
   input  logic [size_lp-1:0]          wr_size_i,
   input  logic                        wr_abort_i,
   output logic                        rd_avail_o,
   output logic [size_lp-1:0]          rd_size_o,
   input  logic                        rd_v_i,
   input  logic [waddr_lp-1:0]         rd_addr_i,
   output logic [data_width_p-1:0]     rd_data_o,
   output logic                        rd_data_v_o,
   input  logic                        rd_ack_i,
   output logic [cnt_lp-1:0]           count_o,
   output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

   localparam int unsigned ptr_lp = (slot_p > 1) ? $clog2(slot_p) : 1;

   logic [ptr_lp-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic [cnt_lp-1:0]           count_q, count_d;
   logic [drop_cnt_width_p-1:0] drop_q, drop_d;
   logic                        rd_v_q, rd_v_d;
   logic [data_width_p-1:0]     rd_data_q, rd_data_d;

   logic                        wr_en_c, rd_en_c, size_ok_c, commit_ok_c, commit_rej_c, ack_ok_c;
   logic [data_width_p-1:0]     wr_bits_c;
   logic [data_width_p-1:0]     slot_rd_c   [slot_p];
   logic [size_lp-1:0]          slot_size_c [slot_p];

   // Pointers wrap by explicit compare so any slot count works
   function automatic logic [ptr_lp-1:0] ptr_inc(input logic [ptr_lp-1:0] p);
      return (p == ptr_lp'(slot_p - 1)) ? '0 : p + ptr_lp'(1);
   endfunction

   assign wr_req_o    = (count_q != cnt_lp'(slot_p));
   assign rd_avail_o  = (count_q != '0);
   assign count_o     = count_q;
   assign drop_cnt_o  = drop_q;
   assign rd_data_o   = rd_data_q;
   assign rd_data_v_o = rd_v_q;
   assign rd_size_o   = slot_size_c[rptr_q];

   assign wr_en_c      = wr_v_i & wr_req_o;
   assign rd_en_c      = rd_v_i & rd_avail_o;
   assign size_ok_c    = (wr_size_i != '0) && (wr_size_i <= size_lp'(els_p));
   assign commit_ok_c  = wr_commit_i & wr_req_o & ~wr_abort_i & size_ok_c;
   assign commit_rej_c = wr_commit_i & ~wr_abort_i & ~commit_ok_c;
   assign ack_ok_c     = rd_ack_i & rd_avail_o;

   for (genvar b = 0; b < bytes_lp; b++) begin : g_mask
      assign wr_bits_c[b*8 +: 8] = {8{wr_mask_i[b]}};
   end

   // Per-slot storage: byte-masked word memory (never reset) plus packet size register
   for (genvar s = 0; s < slot_p; s++) begin : g_slot
      logic [data_width_p-1:0] mem_q [words_lp];
      logic [size_lp-1:0]      size_q;

      always_ff @(posedge clk_i) begin
         if (wr_en_c && (wptr_q == ptr_lp'(s))) begin
            mem_q[wr_addr_i] <= (mem_q[wr_addr_i] & ~wr_bits_c) | (wr_data_i & wr_bits_c);
         end
      end

      always_ff @(posedge clk_i) begin
         if (!reset_n_i) begin
            size_q <= '0;
         end else if (commit_ok_c && (wptr_q == ptr_lp'(s))) begin
            size_q <= wr_size_i;
         end
      end

      assign slot_rd_c[s]   = mem_q[rd_addr_i];
      assign slot_size_c[s] = size_q;
   end

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      drop_d    = drop_q;
      rd_v_d    = rd_en_c;
      rd_data_d = rd_data_q;

      if (commit_ok_c) begin
         wptr_d = ptr_inc(wptr_q);
      end
      if (ack_ok_c) begin
         rptr_d = ptr_inc(rptr_q);
      end
      case ({commit_ok_c, ack_ok_c})
         2'b10:   count_d = count_q + cnt_lp'(1);
         2'b01:   count_d = count_q - cnt_lp'(1);
         default: count_d = count_q;
      endcase
      if (commit_rej_c && (drop_q != '1)) begin
         drop_d = drop_q + drop_cnt_width_p'(1);
      end
      // Read uses the pre-ack rptr, so a read in the ack cycle sees the released slot
      if (rd_en_c) begin
         rd_data_d = slot_rd_c[rptr_q];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         drop_q    <= '0;
         rd_v_q    <= 1'b0;
         rd_data_q <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         drop_q    <= drop_d;
         rd_v_q    <= rd_v_d;
         rd_data_q <= rd_data_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!$isunknown({wr_v_i, wr_commit_i, wr_abort_i, rd_v_i, rd_ack_i}))
            else $error("unknown value on a strobe input");
      end
      assert (data_width_p == 32 || data_width_p == 64 || data_width_p == 128)
         else $error("data_width_p must be 32, 64 or 128");
      assert ((els_p % bytes_lp) == 0)
         else $error("els_p must be a multiple of the word byte count");
   end
`endif

endmodule

// File: tb/tb_packet_ring_buffer.sv
// Scoreboarded bench for packet_ring_buffer: 4-slot/64-bit instance for the main
// behaviour plus a 3-slot instance for non-power-of-two pointer wrap.
module tb_packet_ring_buffer;
   localparam int unsigned WA  = 8;
   localparam int unsigned SZ  = 12;
   localparam int unsigned CW  = 3;
   localparam int unsigned CW3 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          wr_req, wr_v, wr_commit, wr_abort, rd_avail, rd_v, rd_ack, rd_data_v;
   logic [WA-1:0] wr_addr, rd_addr;
   logic [63:0]   wr_data, rd_data;
   logic [7:0]    wr_mask;
   logic [SZ-1:0] wr_size, rd_size;
   logic [CW-1:0] count;
   logic [15:0]   drop_cnt;

   logic           w3_wr_req, w3_commit, w3_ack, w3_rd_avail, w3_rd_data_v, w3_zero;
   logic [SZ-1:0]  w3_size, w3_rd_size;
   logic [63:0]    w3_rd_data;
   logic [CW3-1:0] w3_count;
   logic [15:0]    w3_drop;

   packet_ring_buffer u_dut (
      .clk_i(clk), .reset_n_i(reset_n), .wr_req_o(wr_req), .wr_v_i(wr_v),
      .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
      .wr_commit_i(wr_commit), .wr_size_i(wr_size), .wr_abort_i(wr_abort),
      .rd_avail_o(rd_avail), .rd_size_o(rd_size), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data), .rd_data_v_o(rd_data_v), .rd_ack_i(rd_ack),
      .count_o(count), .drop_cnt_o(drop_cnt)
   );

   packet_ring_buffer #(.slot_p(3)) u_dut3 (
      .clk_i(clk), .reset_n_i(reset_n), .wr_req_o(w3_wr_req), .wr_v_i(w3_zero),
      .wr_addr_i(WA'(0)), .wr_data_i(64'd0), .wr_mask_i(8'd0),
      .wr_commit_i(w3_commit), .wr_size_i(w3_size), .wr_abort_i(w3_zero),
      .rd_avail_o(w3_rd_avail), .rd_size_o(w3_rd_size), .rd_v_i(w3_zero), .rd_addr_i(WA'(0)),
      .rd_data_o(w3_rd_data), .rd_data_v_o(w3_rd_data_v), .rd_ack_i(w3_ack),
      .count_o(w3_count), .drop_cnt_o(w3_drop)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      logic [63:0] data;
      int          due;
   } rd_exp_t;
   rd_exp_t rdq[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: each accepted read must produce its data exactly one cycle later
   always @(negedge clk) begin
      if (rd_data_v) begin
         if (rdq.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            rd_exp_t e;
            e = rdq.pop_front();
            chk("rd_latency", cyc, e.due);
            chk("rd_data", rd_data, e.data);
         end
      end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
         void'(rdq.pop_front());
         chk("rd_missing", 0, 1);
      end
   end

   function automatic logic [63:0] pat(input int s, input int w);
      return {32'hC0DE_0000 + 32'(s), 32'h0000_1000 + 32'(w * 7)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_v = 0; wr_commit = 0; wr_abort = 0; rd_v = 0; rd_ack = 0; wr_mask = '0;
   endtask

   task automatic wr_word(input logic [WA-1:0] a, input logic [63:0] d, input logic [7:0] m);
      wr_v = 1; wr_addr = a; wr_data = d; wr_mask = m;
      tick(); idle();
   endtask

   task automatic commit(input logic [SZ-1:0] sz, input logic ack, input logic abort);
      wr_commit = 1; wr_size = sz; rd_ack = ack; wr_abort = abort;
      tick(); idle();
   endtask

   task automatic ack_pkt();
      rd_ack = 1;
      tick(); idle();
   endtask

   task automatic rd_word(input logic [WA-1:0] a, input logic [63:0] e, input logic ack);
      rd_exp_t x;
      x.data = e;
      x.due  = cyc + 1;
      rdq.push_back(x);
      rd_v = 1; rd_addr = a; rd_ack = ack;
      tick(); idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      wr_addr = '0; wr_data = '0; wr_size = '0; rd_addr = '0; reset_n = 0;
      w3_zero = 0; w3_commit = 0; w3_ack = 0; w3_size = '0;
      tick(); tick();
      reset_n = 1;
      chk("rst_wr_req", wr_req, 1);
      chk("rst_rd_avail", rd_avail, 0);
      chk("rst_count", count, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_rd_data_v", rd_data_v, 0);
      chk("rst_rd_data", rd_data, 0);

      // Size rejects while empty
      commit(SZ'(0), 0, 0);
      chk("rej_size0_drop", drop_cnt, 1);
      chk("rej_size0_count", count, 0);
      commit(SZ'(2049), 0, 0);
      chk("rej_oversize_drop", drop_cnt, 2);
      chk("rej_oversize_count", count, 0);

      // Fill all four slots with 3 words each
      for (int s = 0; s < 4; s++) begin
         for (int w = 0; w < 3; w++) wr_word(WA'(w), pat(s, w), 8'hFF);
         commit(SZ'(24), 0, 0);
         chk("fill_count", count, s + 1);
      end
      chk("full_wr_req", wr_req, 0);
      chk("full_rd_avail", rd_avail, 1);
      chk("full_rd_size", rd_size, 24);

      wr_word(WA'(1), 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
      commit(SZ'(24), 0, 0);
      chk("rej_full_drop", drop_cnt, 3);
      chk("rej_full_count", count, 4);
      rd_word(WA'(1), pat(0, 1), 0);

      // Full: commit rejected even with a same-cycle ack
      commit(SZ'(24), 1, 0);
      chk("full_cmt_ack_count", count, 3);
      chk("full_cmt_ack_drop", drop_cnt, 4);
      ack_pkt();
      chk("ack_count", count, 2);

      // Count 2: accepted commit plus ack keeps the count
      wr_word(WA'(0), 64'h5555_AAAA_0000_0001, 8'hFF);
      commit(SZ'(40), 1, 0);
      chk("cmt_ack_count", count, 2);
      chk("cmt_ack_rd_size", rd_size, 24);
      rd_word(WA'(2), pat(3, 2), 1);
      chk("rd_ack_count", count, 1);
      chk("rd_size_40", rd_size, 40);
      rd_word(WA'(0), 64'h5555_AAAA_0000_0001, 0);
      ack_pkt();
      chk("drain_rd_avail", rd_avail, 0);
      chk("drain_wr_req", wr_req, 1);
      ack_pkt();
      chk("empty_ack_count", count, 0);

      // Abort discards the slot; abort beats commit
      wr_word(WA'(0), 64'hDEAD_BEEF_0000_0000, 8'hFF);
      wr_abort = 1; tick(); idle();
      commit(SZ'(8), 0, 1);
      chk("abort_cmt_count", count, 0);
      chk("abort_cmt_drop", drop_cnt, 4);
      wr_word(WA'(0), 64'h1111, 8'hFF);
      commit(SZ'(8), 0, 0);
      chk("abort_count", count, 1);
      chk("abort_rd_size", rd_size, 8);
      rd_word(WA'(0), 64'h1111, 1);
      chk("abort_ack_count", count, 0);

      // Byte masks: half-word mask, then an all-zero mask that must not write
      wr_word(WA'(0), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      wr_word(WA'(0), 64'h0, 8'h0F);
      wr_word(WA'(0), 64'h1234_5678_9ABC_DEF0, 8'h00);
      commit(SZ'(8), 0, 0);
      rd_word(WA'(0), 64'hFFFF_FFFF_0000_0000, 0);

      // Reset with two packets held and a read issued in the reset cycle
      wr_word(WA'(0), 64'h7777, 8'hFF);
      commit(SZ'(16), 0, 0);
      chk("pre_rst_count", count, 2);
      rd_v = 1; rd_addr = '0; reset_n = 0;
      tick(); idle(); reset_n = 1;
      chk("post_rst_rd_avail", rd_avail, 0);
      chk("post_rst_rd_data_v", rd_data_v, 0);
      chk("post_rst_count", count, 0);
      chk("post_rst_wr_req", wr_req, 1);
      chk("post_rst_drop", drop_cnt, 0);
      chk("post_rst_rd_data", rd_data, 0);

      // Three-slot wrap: two packets outstanding, sizes 60..66 in order
      w3_commit = 1; w3_size = SZ'(60); tick();
      w3_size = SZ'(61); tick();
      w3_commit = 0;
      for (int i = 0; i < 7; i++) begin
         chk("wrap_rd_size", w3_rd_size, 60 + i);
         chk("wrap_count", w3_count, (i == 6) ? 1 : 2);
         w3_ack = 1;
         if (i + 2 <= 6) begin
            w3_commit = 1;
            w3_size = SZ'(60 + i + 2);
         end
         tick();
         w3_ack = 0; w3_commit = 0;
      end
      chk("wrap_final_count", w3_count, 0);
      chk("wrap_drop", w3_drop, 0);

      tick(); tick(); tick();
      chk("rdq_drained", rdq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
